// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: cathode patterns {g,f,e,d,c,b,a} (active-low),
// scan FSM states and display geometry.
package seg7_pkg;

  localparam int unsigned DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low segment pattern; non-decimal values show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Four-digit multiplexed common-anode seven-segment scanner with frame-aligned
// commit, leading-zero blanking and a per-slot all-anodes-off ghosting guard.
module bcd_sevenseg_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done,
  output logic        bcd_err
);

  localparam int unsigned DRIVE_CYCLES = REFRESH_DIV - BLANK_CYCLES;
  localparam int unsigned CW           = $clog2(REFRESH_DIV + 1);

  scan_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;
  logic          frame_end;

  logic [19:0]   pending, committed;
  logic [15:0]   digits;
  logic [3:0]    dps;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [3:0]    lz_mask;
  logic          err_next;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;

  assign digits = committed[19:4];
  assign dps    = committed[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // cnt holds the cycles left in the current state; zero only occurs straight
  // out of reset and just arms the first guard interval.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    frame_end  = 1'b0;
    if (cnt == '0) begin
      cnt_next = CW'(BLANK_CYCLES);
    end else if (cnt == CW'(1)) begin
      if (state == BLANK) begin
        state_next = DRIVE;
        cnt_next   = CW'(DRIVE_CYCLES);
      end else begin
        state_next = BLANK;
        cnt_next   = CW'(BLANK_CYCLES);
        idx_next   = idx + 2'd1;
        frame_end  = (idx == 2'(DIGITS - 1));
      end
    end else begin
      cnt_next = cnt - CW'(1);
    end
  end

  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (digits[15:12] == 4'd0);
    lz_mask[2] = lz_mask[3] && (digits[11:8] == 4'd0);
    lz_mask[1] = lz_mask[2] && (digits[7:4] == 4'd0);
    if (!LZ_BLANK) lz_mask = '0;
  end

  assign nib = digits[{idx_next, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nib),
    .seg    (dec_seg)
  );

  // Outputs are precomputed from the state being entered so the registers
  // change on the same edge as the state.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    dp_d  = 1'b1;
    if (state_next == DRIVE) begin
      an_d[idx_next] = 1'b0;
      seg_d          = lz_mask[idx_next] ? SEG_BLANK : dec_seg;
      dp_d           = ~dps[idx_next];
    end
  end

  always_comb begin
    err_next = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] > 4'd9) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      committed <= '0;
    end else begin
      if (bcd_valid) pending <= {bcd_in, dp_in};
      if (frame_end) committed <= bcd_valid ? {bcd_in, dp_in} : pending;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_done <= frame_end;
      bcd_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed bench for bcd_sevenseg_scan at REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame),
// with a second instance running LZ_BLANK=0 in lockstep.
module tb_bcd_sevenseg_scan;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PD = 7'b0111111;
  localparam logic [6:0] PB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n, seg_n2;
  logic        dp_n, dp_n2;
  logic [3:0]  an_n, an_n2;
  logic        frame_done, frame_done2;
  logic        bcd_err, bcd_err2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_cyc;

  logic [3:0] c_an_blank [4];
  logic [3:0] c_an       [4];
  logic [6:0] c_seg      [4];
  logic [6:0] c_seg2     [4];
  logic       c_dp       [4];
  logic       c_err;

  always #5 clk = ~clk;

  bcd_sevenseg_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .dp_in(dp_in),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done), .bcd_err(bcd_err)
  );

  bcd_sevenseg_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .dp_in(dp_in),
    .seg_n(seg_n2), .dp_n(dp_n2), .an_n(an_n2), .frame_done(frame_done2), .bcd_err(bcd_err2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    bcd_in    = v;
    dp_in     = dp;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  // Returns at the negedge that observes frame_done; n = negedges waited.
  task automatic wait_frame(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    check("frame_done_seen", 16'(frame_done), 16'd1);
  endtask

  // Called at frame offset 0; samples each slot in BLANK (t=8k+1) and DRIVE (t=8k+4).
  task automatic capture();
    for (int unsigned t = 1; t < 32; t++) begin
      @(negedge clk);
      if (t == 1) c_err = bcd_err;
      if (t % 8 == 1) c_an_blank[t/8] = an_n;
      if (t % 8 == 4) begin
        c_an[t/8]   = an_n;
        c_seg[t/8]  = seg_n;
        c_seg2[t/8] = seg_n2;
        c_dp[t/8]   = dp_n;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bcd_in = '0; dp_in = '0; bcd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an",    16'(an_n), 16'hF);
    check("rst_seg",   16'(seg_n), 16'h7F);
    check("rst_dp",    16'(dp_n), 16'd1);
    check("rst_frame", 16'(frame_done), 16'd0);
    check("rst_err",   16'(bcd_err), 16'd0);

    rst = 1'b0;
    @(posedge clk); #1 check("edge1_an", 16'(an_n), 16'hF);
    @(posedge clk); #1 check("edge2_an", 16'(an_n), 16'hF);
    @(posedge clk); #1 check("edge3_an", 16'(an_n), 16'hE);
    check("edge3_seg", 16'(seg_n), 16'(P0));
    wait_frame(n_cyc);
    wait_frame(n_cyc);
    check("frame_period", 16'(n_cyc), 16'd32);

    // 1234 with dp on digit1
    load(16'h1234, 4'b0010);
    wait_frame(n_cyc);
    capture();
    for (int k = 0; k < 4; k++) check("slot_guard_an", 16'(c_an_blank[k]), 16'hF);
    check("d0_an",  16'(c_an[0]), 16'hE);
    check("d0_seg", 16'(c_seg[0]), 16'(P4));
    check("d0_dp",  16'(c_dp[0]), 16'd1);
    check("d1_an",  16'(c_an[1]), 16'hD);
    check("d1_seg", 16'(c_seg[1]), 16'(P3));
    check("d1_dp",  16'(c_dp[1]), 16'd0);
    check("d2_seg", 16'(c_seg[2]), 16'(P2));
    check("d3_an",  16'(c_an[3]), 16'h7);
    check("d3_seg", 16'(c_seg[3]), 16'(P1));

    // leading-zero blanking
    load(16'h0007, 4'b0000);
    wait_frame(n_cyc);
    capture();
    check("lz7_d0", 16'(c_seg[0]), 16'(P7));
    check("lz7_d1", 16'(c_seg[1]), 16'(PB));
    check("lz7_d2", 16'(c_seg[2]), 16'(PB));
    check("lz7_d3", 16'(c_seg[3]), 16'(PB));
    check("lz7_d3_an", 16'(c_an[3]), 16'h7);
    check("nolz7_d3", 16'(c_seg2[3]), 16'(P0));
    check("nolz7_d0", 16'(c_seg2[0]), 16'(P7));

    load(16'h0000, 4'b0000);
    wait_frame(n_cyc);
    capture();
    check("lz0_d0", 16'(c_seg[0]), 16'(P0));
    check("lz0_d1", 16'(c_seg[1]), 16'(PB));

    load(16'h0400, 4'b0000);
    wait_frame(n_cyc);
    capture();
    check("lz400_d0", 16'(c_seg[0]), 16'(P0));
    check("lz400_d1", 16'(c_seg[1]), 16'(P0));
    check("lz400_d2", 16'(c_seg[2]), 16'(P4));
    check("lz400_d3", 16'(c_seg[3]), 16'(PB));

    // tear-free commit
    load(16'h1111, 4'b0000);
    wait_frame(n_cyc);
    repeat (12) @(negedge clk);
    load(16'h2222, 4'b0000);
    repeat (7) @(negedge clk);
    check("tear_d2_an",  16'(an_n), 16'hB);
    check("tear_d2_seg", 16'(seg_n), 16'(P1));
    repeat (8) @(negedge clk);
    check("tear_d3_an",  16'(an_n), 16'h7);
    check("tear_d3_seg", 16'(seg_n), 16'(P1));
    wait_frame(n_cyc);
    capture();
    for (int k = 0; k < 4; k++) check("after_tear_seg", 16'(c_seg[k]), 16'(P2));

    // bypass: strobe lands on the frame_done edge
    bcd_in = 16'h3333; dp_in = 4'b0000; bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
    check("bypass_edge", 16'(frame_done), 16'd1);
    capture();
    for (int k = 0; k < 4; k++) check("bypass_seg", 16'(c_seg[k]), 16'(P3));

    // invalid nibble
    load(16'h00A5, 4'b0000);
    check("err_commit_edge", 16'(bcd_err), 16'd0);
    @(negedge clk);
    check("err_next_cycle", 16'(bcd_err), 16'd1);
    wait_frame(n_cyc);
    capture();
    check("inv_d0", 16'(c_seg[0]), 16'(P5));
    check("inv_d1", 16'(c_seg[1]), 16'(PD));
    check("inv_d2", 16'(c_seg[2]), 16'(PB));
    check("inv_err", 16'(c_err), 16'd1);
    load(16'h0005, 4'b0000);
    check("err_hold", 16'(bcd_err), 16'd1);
    @(negedge clk);
    check("err_clear", 16'(bcd_err), 16'd0);

    // reset during digit2 DRIVE
    load(16'h8888, 4'b0100);
    wait_frame(n_cyc);
    repeat (20) @(negedge clk);
    check("pre_rst_an",  16'(an_n), 16'hB);
    check("pre_rst_seg", 16'(seg_n), 16'(P8));
    check("pre_rst_dp",  16'(dp_n), 16'd0);
    #2 rst = 1'b1;
    #1;
    check("async_an",   16'(an_n), 16'hF);
    check("async_seg",  16'(seg_n), 16'h7F);
    check("async_dp",   16'(dp_n), 16'd1);
    check("async_an2",  16'(an_n2), 16'hF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 check("restart_e1_an", 16'(an_n), 16'hF);
    @(posedge clk);
    @(posedge clk); #1 check("restart_an", 16'(an_n), 16'hE);
    check("restart_seg", 16'(seg_n), 16'(P0));
    check("restart_dp",  16'(dp_n), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
